remainder_divider: RTL and testbench

Sequential 32-bit unsigned restoring divider that sits beside the shift-add multiplier in the ALU datapath and performs the inverse operation. It computes one quotient bit per clock. It uses the same controller-plus-working-register style as the multiplier's Product register: shift every cycle, with a conditional write decided by the subtract result. The result is held stable until the next Start.

---
 rtl/remainder_divider.sv | 100 ++++++++++
 tb/tb_remainder_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/remainder_divider.sv
// remainder_divider: sequential 32-bit unsigned restoring divider.
// Produces one quotient bit per clock: a 32-iteration RUN phase, then the
// result is held in DONE until the next Start. A zero divisor skips RUN and
// reports the all-ones quotient with the dividend as remainder.
module remainder_divider (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] Dividend_in,
    input  logic [31:0] Divisor_in,
    output logic        Busy,
    output logic        Ready,
    output logic        Div_by_zero,
    output logic [31:0] Quotient_out,
    output logic [31:0] Remainder_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [32:0] rem_q;      // partial remainder R
    logic [31:0] quo_q;      // quotient / shifted-out dividend Q
    logic [31:0] dvs_q;      // latched divisor D
    logic [5:0]  cnt_q;      // iteration counter C
    logic        dbz_q;

    logic        accept;
    logic        dvs_zero;
    logic [32:0] trial;
    logic        no_borrow;

    assign accept   = (state == IDLE || state == DONE) && Start;
    assign dvs_zero = (Divisor_in == 32'd0);

    // Shift R:Q left one bit and try to subtract D. R[32] is always clear
    // while R < D, but if it were set the shifted value would exceed any
    // 32-bit divisor, so the subtract is taken unconditionally.
    assign trial     = {rem_q[31:0], quo_q[31]} - {1'b0, dvs_q};
    assign no_borrow = ~trial[32] | rem_q[32];

    // State register
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (Start) state_nxt = dvs_zero ? DONE : RUN;
            RUN:        if (cnt_q == 6'd31) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        Busy  = (state == RUN);
        Ready = (state == DONE);
    end

    // Working registers: load on accept, one restoring step per RUN cycle
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            if (dvs_zero) begin
                rem_q <= {1'b0, Dividend_in};
                quo_q <= 32'hFFFF_FFFF;
                dvs_q <= '0;
                dbz_q <= 1'b1;
            end else begin
                rem_q <= '0;
                quo_q <= Dividend_in;
                dvs_q <= Divisor_in;
                dbz_q <= 1'b0;
            end
        end else if (state == RUN) begin
            cnt_q <= cnt_q + 6'd1;
            if (no_borrow) begin
                rem_q <= trial;
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= {rem_q[31:0], quo_q[31]};
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign Div_by_zero   = dbz_q;
    assign Quotient_out  = quo_q;
    assign Remainder_out = rem_q[31:0];

endmodule

// File: tb/tb_remainder_divider.sv
// tb_remainder_divider: directed and back-to-back random checks of the
// restoring divider, including divide-by-zero, ignored Start and mid-run reset.
module tb_remainder_divider;

    logic        clk;
    logic        Reset_n;
    logic        Start;
    logic [31:0] Dividend_in;
    logic [31:0] Divisor_in;
    logic        Busy;
    logic        Ready;
    logic        Div_by_zero;
    logic [31:0] Quotient_out;
    logic [31:0] Remainder_out;

    int n_chk  = 0;
    int n_fail = 0;

    remainder_divider dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Dividend_in  (Dividend_in),
        .Divisor_in   (Divisor_in),
        .Busy         (Busy),
        .Ready        (Ready),
        .Div_by_zero  (Div_by_zero),
        .Quotient_out (Quotient_out),
        .Remainder_out(Remainder_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One division from IDLE/DONE; optionally re-assert Start with other
    // operands at iteration 'glitch' to confirm it is ignored.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int glitch);
        int cyc;
        Dividend_in = a;
        Divisor_in  = b;
        Start       = 1'b1;
        tick();
        Start = 1'b0;
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        chk({tag, "_rdy_lo"}, {31'd0, Ready}, 32'd0);
        cyc = 0;
        while (!Ready && cyc < 40) begin
            if (cyc == glitch) begin
                Start = 1'b1; Dividend_in = 32'd50; Divisor_in = 32'd5;
            end else if (cyc == glitch + 1) begin
                Start = 1'b0;
            end
            tick();
            cyc++;
        end
        Start = 1'b0;
        chk({tag, "_lat"}, cyc, 32'd32);
        chk({tag, "_q"}, Quotient_out, eq);
        chk({tag, "_r"}, Remainder_out, er);
        chk({tag, "_dbz"}, {31'd0, Div_by_zero}, 32'd0);
        chk({tag, "_busy_lo"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        int cyc;
        Reset_n = 1'b0; Start = 1'b0; Dividend_in = '0; Divisor_in = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_rdy", {31'd0, Ready}, 32'd0);
        chk("rst_dbz", {31'd0, Div_by_zero}, 32'd0);
        chk("rst_q", Quotient_out, 32'd0);
        chk("rst_r", Remainder_out, 32'd0);
        Reset_n = 1'b1;
        tick();

        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, -1);
        // Result is a held level
        repeat (5) tick();
        chk("hold_rdy", {31'd0, Ready}, 32'd1);
        chk("hold_q", Quotient_out, 32'd14);
        chk("hold_r", Remainder_out, 32'd2);

        run_div("ffff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, -1);
        run_div("ffff_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, -1);
        run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, -1);
        run_div("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, -1);
        run_div("d7_2", 32'h8000_0001, 32'd2, 32'h4000_0000, 32'd1, -1);

        // Divide by zero: result one edge after Start, never busy
        Dividend_in = 32'd5; Divisor_in = 32'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("dbz_rdy", {31'd0, Ready}, 32'd1);
        chk("dbz_flag", {31'd0, Div_by_zero}, 32'd1);
        chk("dbz_busy", {31'd0, Busy}, 32'd0);
        chk("dbz_q", Quotient_out, 32'hFFFF_FFFF);
        chk("dbz_r", Remainder_out, 32'd5);
        tick();
        chk("dbz_busy2", {31'd0, Busy}, 32'd0);
        run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, -1);

        // Start re-asserted mid-run is ignored
        run_div("ign", 32'd1000, 32'd3, 32'd333, 32'd1, 10);

        // Reset during run aborts immediately
        Dividend_in = 32'd1000; Divisor_in = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (16) tick();
        Reset_n = 1'b0;
        #1;
        chk("ab_busy", {31'd0, Busy}, 32'd0);
        chk("ab_rdy", {31'd0, Ready}, 32'd0);
        chk("ab_q", Quotient_out, 32'd0);
        chk("ab_r", Remainder_out, 32'd0);
        tick();
        chk("ab_rdy2", {31'd0, Ready}, 32'd0);
        Reset_n = 1'b1;
        tick();
        chk("ab_idle", {31'd0, Busy}, 32'd0);
        run_div("post_rst", 32'd1000, 32'd3, 32'd333, 32'd1, -1);

        // Back-to-back random pairs with Start held high in DONE
        Start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom() >> $urandom_range(0, 31);
            b = $urandom() >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            Dividend_in = a;
            Divisor_in  = b;
            tick();
            cyc = 0;
            while (!Ready && cyc < 40) begin
                tick();
                cyc++;
            end
            chk("rnd_lat", cyc, 32'd32);
            chk("rnd_q", Quotient_out, a / b);
            chk("rnd_r", Remainder_out, a % b);
        end
        Start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
